dram_burst_ctrl: RTL and testbench
==================================

# dram_burst_ctrl

Parametrised single-port DRAM controller between the on-chip bus slave port and the off-chip DRAM model. It accepts one burst request at a time, reads or writes up to 256 consecutive words within one DRAM row, and generates ACT/RD/WR/PRE command sequences with configurable tRCD/tCL/tRP. Unlike the fixed-timing wrapper generation, it supports an open-page policy: a request that hits the currently open row skips precharge and activate.

## Interface
Parameters:
- DATA_W, 32: DRAM/bus data width; STRB_W = DATA_W/8.
- ROW_W, 11: row address bits; also the width of DRAM_A_o.
- COL_W, 10: column address bits; COL_W <= ROW_W.
- T_RCD, 5: cycles from ACT to first column command; >= 1.
- T_CL, 5: cycles reserved after each column command; >= 1.
- T_RP, 5: cycles from PRE to the next ACT or IDLE; >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid / req_ready  in/out  1  request handshake.
- req_write  in  1  1 = write burst.
- req_addr  in  ROW_W+COL_W+2  byte address; [1:0] ignored.
- req_len  in  8  beats minus 1.
- wdata / wstrb  in  DATA_W / STRB_W  write beat.
- wvalid / wready  in/out  1  write-beat handshake.
- rdata  out  DATA_W  read beat, registered.
- rvalid / rready / rlast  out/in/out  1  read-beat handshake.
- bvalid / bready  out/in  1  write response. Response is always OKAY, so no resp port.
- DRAM_Q_i / DRAM_valid_i  in  DATA_W / 1  DRAM read data.
- DRAM_CSn_o, DRAM_RASn_o, DRAM_CASn_o  out  1  active-low commands.
- DRAM_WEn_o  out  STRB_W  active-low byte write enables.
- DRAM_A_o  out  ROW_W  row or zero-extended column.
- DRAM_D_o  out  DATA_W  write data.

## Operation
- Address decode: word = req_addr[ROW_W+COL_W+1:2]; row = upper ROW_W bits; col = lower COL_W bits.
- Column increments by 1 per beat modulo 2^COL_W. Bursts wrap within the row and never cross it.
- States:
  - IDLE: req_ready=1. On request handshake, latch write, row, col and len, then go to:
    - WR/RD if the row is open and matches;
    - PRE if a different row is open;
    - ACT if no row is open.
  - PRE: one-cycle command (CSn=0, RASn=0, CASn=1, WEn=0, A=open row), then wait until T_RP total cycles have elapsed. Clear row_open; go to ACT.
  - ACT: one-cycle command (CSn=0, RASn=0, A=row), then wait until T_RCD total cycles have elapsed. Set row_open and open_row; go to RD or WR.
  - RD, per beat:
    - Issue CAS (CSn=0, CASn=0, WEn all 1, A=col).
    - On DRAM_valid_i, register DRAM_Q_i into rdata and assert rvalid. Hold rvalid and rdata stable until rready.
    - The next CAS is issued in the cycle after the read handshake, but no earlier than T_CL cycles after the previous CAS.
    - rlast = (beat count == len).
    - After the last read handshake, go to CLOSE.
  - WR, per beat:
    - wready=1 only while no column command is pending.
    - On write handshake, register wdata/wstrb. Next cycle issue CAS with WEn=~wstrb and D=registered data, then wait T_CL.
    - After the last beat's wait, assert bvalid until bready, then go to CLOSE.
  - CLOSE: without OPEN_PAGE_EN go to PRE and then IDLE. With OPEN_PAGE_EN go directly to IDLE, keeping the row open.
- Idle command bus: CSn=RASn=CASn=1, WEn all 1, A=0, D=0.
- Wait counter width is $clog2(max(T_RCD,T_CL,T_RP)+1). The beat counter is 8 bits.
- wvalid during RD, or outside WR, is ignored. wready=0 there.

## Timing
- Reset values: req_ready=0 during reset and 1 in the first cycle after release; rvalid=rlast=bvalid=wready=0; rdata=0; DRAM_CSn/RASn/CASn=1; DRAM_WEn all 1; DRAM_A_o=0; DRAM_D_o=0; row_open=0.
- rst asserted mid-burst aborts the burst immediately. No precharge is issued; row_open=0, so the next request does ACT.
- Closed-row read latency: ACT cycle 0, CAS at cycle T_RCD, rvalid one cycle after DRAM_valid_i.
- Open-row hit: CAS in the cycle after the request handshake.
- Back-pressure: with rready held low, no further CAS is issued and rdata does not change.
- req_len=0 gives a single beat, with rlast asserted together with the first rvalid.
- Column wrap: col=2^COL_W-1 is followed by col=0 in the same row.

## Configuration
- DRAM_OPEN_PAGE_EN defined: the row stays open after a burst. Hits skip PRE/ACT; misses do PRE then ACT.
- DRAM_OPEN_PAGE_EN undefined: every burst ends with PRE plus T_RP. row_open is always 0 in IDLE and every request starts with ACT.

## Test plan
- Reset release: check every output's reset value. Request addr=0x0000_1004, read, len=3 -> ACT with A=row 1, CAS cols 1,2,3,4, four rvalid beats, rlast on the 4th.
- Write addr=0x40, len=0, wstrb=4'b0011, wdata=0xA5A5_1234 -> one CAS with DRAM_WEn_o=4'b1100 and D=0xA5A5_1234, then bvalid. A read-back returns the data.
- OPEN_PAGE_EN: two reads to the same row -> the second has no ACT and CAS one cycle after the handshake. A third read to another row -> PRE, T_RP wait, ACT.
- rready held low for 10 cycles during beat 2 -> rdata stable, no CAS during the stall, burst completes with the correct data.
- Burst starting at col 0x3FE with len=3 -> columns 3FE, 3FF, 000, 001 in the same row.
- rst asserted mid write burst -> outputs return to reset values within the same cycle. A following request starts with ACT.

Source files
------------

// File: rtl/dram_burst_ctrl_if.sv
// dram_burst_ctrl_if: bus-side request, write-beat, read-beat and write-response handshakes.
interface dram_burst_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 23
);
  localparam int STRB_W = DATA_W / 8;
  logic req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0] req_len;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic wvalid, wready;
  logic [DATA_W-1:0] rdata;
  logic rvalid, rready, rlast;
  logic bvalid, bready;
  modport master (
    output req_valid, req_write, req_addr, req_len, wdata, wstrb, wvalid, rready, bready,
    input  req_ready, wready, rdata, rvalid, rlast, bvalid
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata, wstrb, wvalid, rready, bready,
    output req_ready, wready, rdata, rvalid, rlast, bvalid
  );
endinterface

// File: rtl/dram_burst_ctrl.sv
// dram_burst_ctrl: one-burst-at-a-time DRAM controller issuing ACT/RD/WR/PRE with tRCD/tCL/tRP spacing.
// Define DRAM_OPEN_PAGE_EN to leave the row open after a burst so same-row requests skip PRE/ACT.
module dram_burst_ctrl #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 11,
  parameter int COL_W  = 10,
  parameter int T_RCD  = 5,
  parameter int T_CL   = 5,
  parameter int T_RP   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  dram_burst_ctrl_if.slave       bus,
  input  logic [DATA_W-1:0]      DRAM_Q_i,
  input  logic                   DRAM_valid_i,
  output logic                   DRAM_CSn_o,
  output logic                   DRAM_RASn_o,
  output logic                   DRAM_CASn_o,
  output logic [DATA_W/8-1:0]    DRAM_WEn_o,
  output logic [ROW_W-1:0]       DRAM_A_o,
  output logic [DATA_W-1:0]      DRAM_D_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int TMAX = T_RCD > T_CL ? (T_RCD > T_RP ? T_RCD : T_RP) : (T_CL > T_RP ? T_CL : T_RP);
  localparam int CW = $clog2(TMAX + 1);
`ifdef DRAM_OPEN_PAGE_EN
  localparam bit OPEN_PAGE = 1'b1;
`else
  localparam bit OPEN_PAGE = 1'b0;
`endif
  typedef enum logic [3:0] {IDLE, PRE, TRP, ACT, TRCD, RD_CAS, RD_WAIT, WR_DAT, WR_CAS, WR_WAIT, RESP, CLOSE} state_t;
  state_t state_q, state_d, pre_nxt, col_st, wr_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d, open_row_q, open_row_d, req_row;
  logic [COL_W-1:0] col_q, col_d, req_col;
  logic [7:0] len_q, len_d, beat_q, beat_d;
  logic wr_q, wr_d, last_q, last_d, hs_q, hs_d, fin_q, fin_d, open_q, open_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wd_q, wd_d;
  logic [STRB_W-1:0] ws_q, ws_d;
  logic ready, req_hs, r_hs, w_hs, t_ok;
  assign req_row = bus.req_addr[ROW_W+COL_W+1:COL_W+2];
  assign req_col = bus.req_addr[COL_W+1:2];
  assign req_hs  = bus.req_valid && ready;
  assign r_hs    = rvalid_q && bus.rready;
  assign w_hs    = state_q == WR_DAT && bus.wvalid;
  assign t_ok    = cnt_q <= CW'(1);
  assign pre_nxt = fin_q ? IDLE : ACT;
  assign col_st  = wr_q ? WR_DAT : RD_CAS;
  assign wr_nxt  = last_q ? RESP : WR_DAT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      row_q <= '0;
      open_row_q <= '0;
      col_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      {wr_q, last_q, hs_q, fin_q, open_q, rvalid_q} <= '0;
      rdata_q <= '0;
      wd_q <= '0;
      ws_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      open_row_q <= open_row_d;
      col_q <= col_d;
      len_q <= len_d;
      beat_q <= beat_d;
      {wr_q, last_q, hs_q, fin_q, open_q, rvalid_q} <= {wr_d, last_d, hs_d, fin_d, open_d, rvalid_d};
      rdata_q <= rdata_d;
      wd_q <= wd_d;
      ws_q <= ws_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q == '0 ? '0 : cnt_q - CW'(1);
    row_d = row_q;
    open_row_d = open_row_q;
    col_d = col_q;
    len_d = len_q;
    beat_d = beat_q;
    {wr_d, last_d, hs_d, fin_d, open_d} = {wr_q, last_q, hs_q, fin_q, open_q};
    wd_d = wd_q;
    ws_d = ws_q;
    rvalid_d = r_hs ? 1'b0 : rvalid_q;
    rdata_d = rdata_q;
    if ((state_q == RD_CAS || state_q == RD_WAIT) && DRAM_valid_i) begin
      rvalid_d = 1'b1;
      rdata_d = DRAM_Q_i;
    end
    case (state_q)
      IDLE: begin
        fin_d = 1'b0;
        if (req_hs) begin
          wr_d = bus.req_write;
          row_d = req_row;
          col_d = req_col;
          len_d = bus.req_len;
          beat_d = '0;
          hs_d = 1'b0;
          state_d = !open_q ? ACT : req_row != open_row_q ? PRE : bus.req_write ? WR_DAT : RD_CAS;
        end
      end
      PRE: begin
        open_d = 1'b0;
        cnt_d = CW'(T_RP - 1);
        state_d = T_RP == 1 ? pre_nxt : TRP;
      end
      TRP: state_d = t_ok ? pre_nxt : TRP;
      ACT: begin
        open_d = 1'b1;
        open_row_d = row_q;
        cnt_d = CW'(T_RCD - 1);
        state_d = T_RCD == 1 ? col_st : TRCD;
      end
      TRCD: state_d = t_ok ? col_st : TRCD;
      RD_CAS: begin
        col_d = col_q + COL_W'(1);
        cnt_d = CW'(T_CL - 1);
        hs_d = 1'b0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // the next CAS waits for both the current beat's handshake and tCL
        if (r_hs) begin
          beat_d = beat_q + 8'd1;
          hs_d = 1'b1;
        end
        state_d = (r_hs && beat_q == len_q) ? CLOSE : ((r_hs || hs_q) && t_ok) ? RD_CAS : RD_WAIT;
      end
      WR_DAT: if (w_hs) begin
        wd_d = bus.wdata;
        ws_d = bus.wstrb;
        last_d = beat_q == len_q;
        beat_d = beat_q + 8'd1;
        state_d = WR_CAS;
      end
      WR_CAS: begin
        col_d = col_q + COL_W'(1);
        cnt_d = CW'(T_CL - 1);
        state_d = T_CL == 1 ? wr_nxt : WR_WAIT;
      end
      WR_WAIT: state_d = t_ok ? wr_nxt : WR_WAIT;
      RESP: state_d = bus.bready ? CLOSE : RESP;
      CLOSE: begin
        fin_d = 1'b1;
        state_d = OPEN_PAGE ? IDLE : PRE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ready = state_q == IDLE && !rst;
    bus.req_ready = ready;
    bus.wready = state_q == WR_DAT;
    bus.rdata = rdata_q;
    bus.rvalid = rvalid_q;
    bus.rlast = rvalid_q && beat_q == len_q;
    bus.bvalid = state_q == RESP;
    DRAM_CSn_o = !(state_q inside {PRE, ACT, RD_CAS, WR_CAS});
    DRAM_RASn_o = !(state_q inside {PRE, ACT});
    DRAM_CASn_o = !(state_q inside {RD_CAS, WR_CAS});
    DRAM_WEn_o = state_q == PRE ? '0 : state_q == WR_CAS ? ~ws_q : '1;
    DRAM_A_o = state_q == PRE ? open_row_q : state_q == ACT ? row_q :
               state_q inside {RD_CAS, WR_CAS} ? ROW_W'(col_q) : '0;
    DRAM_D_o = state_q == WR_CAS ? wd_q : '0;
  end
endmodule

// File: tb/tb_dram_burst_ctrl.sv
// tb_dram_burst_ctrl: directed bursts against a command log and a byte-merging DRAM model.
`timescale 1ns/1ps
module tb_dram_burst_ctrl;
  localparam int T_RCD = 5, T_CL = 5, T_RP = 5;
`ifdef DRAM_OPEN_PAGE_EN
  localparam bit OPEN = 1'b1;
`else
  localparam bit OPEN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  dram_burst_ctrl_if #(.DATA_W(32), .ADDR_W(23)) bus ();
  logic [31:0] q, d;
  logic qv, csn, rasn, casn;
  logic [3:0] wen;
  logic [10:0] a;
  dram_burst_ctrl #(.DATA_W(32), .ROW_W(11), .COL_W(10), .T_RCD(T_RCD), .T_CL(T_CL), .T_RP(T_RP)) dut (
    .clk(clk), .rst(rst), .bus(bus), .DRAM_Q_i(q), .DRAM_valid_i(qv),
    .DRAM_CSn_o(csn), .DRAM_RASn_o(rasn), .DRAM_CASn_o(casn),
    .DRAM_WEn_o(wen), .DRAM_A_o(a), .DRAM_D_o(d)
  );
  typedef struct {int c; int k; logic [10:0] a; logic [3:0] we; logic [31:0] d;} cmd_t;
  cmd_t cmds[$];
  cmd_t e;
  int cyc = 0, cas_cnt = 0, total = 0, bad = 0, hs = 0;
  logic [31:0] mem [0:8191];
  logic wf [0:8191];
  logic [31:0] cur;
  logic [10:0] mrow = '0;
  logic p1 = 1'b0;
  logic [12:0] a1 = '0;
  logic [31:0] got[$];
  logic [7:0] lasts;
  // unwritten locations read back as C0DE_0000 | {row[2:0], col}
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1 <= 1'b0;
    qv <= p1;
    q <= wf[a1] ? mem[a1] : (32'hC0DE_0000 | {19'h0, a1});
    if (!rst && !csn) begin
      e.c = cyc; e.a = a; e.we = wen; e.d = d;
      e.k = (!rasn && casn) ? (wen == 4'h0 ? 0 : 1) : (wen == 4'hF ? 2 : 3);
      cmds.push_back(e);
      if (e.k == 1) mrow <= a;
      if (e.k >= 2) cas_cnt <= cas_cnt + 1;
      if (e.k == 2) begin
        p1 <= 1'b1;
        a1 <= {mrow[2:0], a[9:0]};
      end
      if (e.k == 3) begin
        cur = wf[{mrow[2:0], a[9:0]}] ? mem[{mrow[2:0], a[9:0]}] : (32'hC0DE_0000 | {19'h0, mrow[2:0], a[9:0]});
        for (int i = 0; i < 4; i++) if (!wen[i]) cur[8*i +: 8] = d[8*i +: 8];
        mem[{mrow[2:0], a[9:0]}] <= cur;
        wf[{mrow[2:0], a[9:0]}] <= 1'b1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
    end
  endtask
  function automatic int count(input int k);
    int n = 0;
    foreach (cmds[i]) if (cmds[i].k == k) n++;
    return n;
  endfunction
  function automatic int find(input int k);
    for (int i = cmds.size() - 1; i >= 0; i--) if (cmds[i].k == k) return i;
    return 0;
  endfunction
  task automatic req(input logic w, input logic [22:0] addr, input logic [7:0] len);
    int t = 0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = addr; bus.req_len = len;
    while (!bus.req_ready && t < 200) begin @(negedge clk); t++; end
    cmds.delete();
    hs = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (t >= 200) chk("req_timeout", t, 0);
  endtask
  task automatic wait_idle();
    int t = 0;
    while (!bus.req_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("idle_timeout", t, 0);
  endtask
  task automatic rd_burst(input int n, input int stall);
    int b = 0, t = 0, c0;
    logic [31:0] hold;
    got.delete();
    lasts = '0;
    bus.rready = 1'b1;
    while (b < n && t < 1000) begin
      if (bus.rvalid) begin
        if (b == stall) begin
          hold = bus.rdata;
          c0 = cas_cnt;
          bus.rready = 1'b0;
          repeat (10) @(negedge clk);
          chk("stall_rdata", bus.rdata, hold);
          chk("stall_rvalid", 32'(bus.rvalid), 1);
          chk("stall_cas", cas_cnt - c0, 0);
          bus.rready = 1'b1;
        end
        got.push_back(bus.rdata);
        lasts[b] = bus.rlast;
        b++;
      end
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("rd_timeout", b, n);
  endtask
  task automatic wr_beat(input logic [31:0] dat, input logic [3:0] s);
    int t = 0;
    bus.wvalid = 1'b1; bus.wdata = dat; bus.wstrb = s;
    while (!bus.wready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    bus.wvalid = 1'b0;
    if (t >= 200) chk("w_timeout", t, 0);
  endtask
  task automatic wr_resp();
    int t = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && t < 200) begin @(negedge clk); t++; end
    chk("bvalid", 32'(bus.bvalid), 1);
    @(negedge clk);
    bus.bready = 1'b0;
  endtask
  initial begin
    int j, k;
    logic [9:0] ec [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [31:0] ed [4] = '{32'hC0DE_17FE, 32'hC0DE_17FF, 32'hC0DE_1400, 32'hC0DE_1401};
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_len = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.rready = 0; bus.bready = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_wready", 32'(bus.wready), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rlast", 32'(bus.rlast), 0);
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_csn", 32'(csn), 1);
    chk("rst_rasn", 32'(rasn), 1);
    chk("rst_casn", 32'(casn), 1);
    chk("rst_wen", 32'(wen), 32'hF);
    chk("rst_a", 32'(a), 0);
    chk("rst_d", d, 0);
    rst = 1'b0;
    #1 chk("rel_req_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    // closed-row read, row 1 cols 1..4
    req(1'b0, 23'h1004, 8'd3);
    rd_burst(4, -1);
    wait_idle();
    chk("t1_act", cmds[0].k, 1);
    chk("t1_act_a", 32'(cmds[0].a), 1);
    chk("t1_act_c", cmds[0].c, hs + 1);
    chk("t1_trcd", cmds[1].c - cmds[0].c, T_RCD);
    for (int i = 0; i < 4; i++) begin
      chk("t1_cas_k", cmds[1+i].k, 2);
      chk("t1_cas_col", 32'(cmds[1+i].a), 1 + i);
      chk("t1_data", got[i], 32'hC0DE_0401 + i);
    end
    chk("t1_rlast", 32'(lasts), 32'h8);
    chk("t1_ncmd", cmds.size(), OPEN ? 5 : 6);
    // single-beat partial write to row 0 col 0x10, then read-back
    req(1'b1, 23'h40, 8'd0);
    wr_beat(32'hA5A5_1234, 4'b0011);
    wr_resp();
    wait_idle();
    k = find(3);
    chk("t2_nwr", count(3), 1);
    chk("t2_wen", 32'(cmds[k].we), 32'hC);
    chk("t2_d", cmds[k].d, 32'hA5A5_1234);
    chk("t2_col", 32'(cmds[k].a), 32'h10);
    chk("t2_first", cmds[0].k, OPEN ? 0 : 1);
    req(1'b0, 23'h40, 8'd0);
    rd_burst(1, -1);
    wait_idle();
    chk("t2_rb", got[0], 32'hC0DE_1234);
    chk("t2_rlast", 32'(lasts), 1);
    // same-row pair then a different row
    req(1'b0, 23'h2000, 8'd0);
    rd_burst(1, -1);
    wait_idle();
    req(1'b0, 23'h2008, 8'd0);
    rd_burst(1, -1);
    wait_idle();
    chk("t3_hit_k", cmds[0].k, OPEN ? 2 : 1);
    chk("t3_hit_c", cmds[0].c, hs + 1);
    chk("t3_hit_data", got[0], 32'hC0DE_0802);
    req(1'b0, 23'h3000, 8'd0);
    rd_burst(1, -1);
    wait_idle();
    chk("t3_miss_k", cmds[0].k, OPEN ? 0 : 1);
    chk("t3_miss_act_c", cmds[OPEN ? 1 : 0].c - hs, OPEN ? 1 + T_RP : 1);
    chk("t3_miss_act_a", 32'(cmds[OPEN ? 1 : 0].a), 3);
    chk("t3_miss_data", got[0], 32'hC0DE_0C00);
    // back-pressure on beat 2
    req(1'b0, 23'h4000, 8'd3);
    rd_burst(4, 1);
    wait_idle();
    for (int i = 0; i < 4; i++) chk("t4_data", got[i], 32'hC0DE_1000 + i);
    chk("t4_ncas", count(2), 4);
    // column wrap inside row 5
    req(1'b0, 23'h5FF8, 8'd3);
    rd_burst(4, -1);
    wait_idle();
    chk("t5_act_a", 32'(cmds[find(1)].a), 5);
    j = 0;
    foreach (cmds[i]) if (cmds[i].k == 2 && j < 4) begin
      chk("t5_col", 32'(cmds[i].a), 32'(ec[j]));
      j++;
    end
    chk("t5_ncas", j, 4);
    for (int i = 0; i < 4; i++) chk("t5_data", got[i], ed[i]);
    chk("t5_rlast", 32'(lasts), 32'h8);
    // reset in the middle of a write burst
    req(1'b1, 23'h6000, 8'd3);
    wr_beat(32'h1111_2222, 4'hF);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_req_ready", 32'(bus.req_ready), 0);
    chk("t6_wready", 32'(bus.wready), 0);
    chk("t6_bvalid", 32'(bus.bvalid), 0);
    chk("t6_csn", 32'(csn), 1);
    chk("t6_casn", 32'(casn), 1);
    chk("t6_wen", 32'(wen), 32'hF);
    chk("t6_a", 32'(a), 0);
    chk("t6_d", d, 0);
    @(negedge clk);
    rst = 1'b0;
    req(1'b0, 23'h6004, 8'd0);
    rd_burst(1, -1);
    wait_idle();
    chk("t6_act", cmds[0].k, 1);
    chk("t6_act_c", cmds[0].c, hs + 1);
    chk("t6_act_a", 32'(cmds[0].a), 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
